// File: rtl/xor_sched_pkg.sv
// Shared types and helpers for the XOR reduction scheduler.
package xor_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Burst length field width of the default build and the longest burst it allows.
   localparam int DEF_LEN_W = 8;
   localparam int MAX_LEN   = (1 << DEF_LEN_W) - 1;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/xor_reduce_sched_rr_arbiter.sv
// Combinational one-hot picker. The search starts at ptr and wraps, so a
// pointer tied to zero gives plain lowest-index-wins priority.
module rr_arbiter
   import xor_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = id_width(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            req_any
);

   // First set request at or after the pointer, wrapping past NREQ-1.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      req_any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!req_any && req[(int'(ptr) + i) % NREQ]) begin
            req_any                           = 1'b1;
            gnt[(int'(ptr) + i) % NREQ]       = 1'b1;
            idx                               = IDW'((int'(ptr) + i) % NREQ);
         end
      end
   end

endmodule

// File: rtl/xor_reduce_sched.sv
// Shares one XOR accumulator between NREQ requesters, one burst at a time.
// Build option: define XOR_SCHED_RR_EN for round-robin arbitration; without it
// the lowest requesting index always wins and no pointer register exists.
//
// state | meaning
// IDLE  | no grant; arbitrate among req and latch winner and its length
// ACCUM | grant held, in_ready high, one word folded in per in_valid
// DONE  | grant held, result presented until res_ready
module xor_reduce_sched
   import xor_sched_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int LEN_W = 8
)(
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ*LEN_W-1:0]       req_len,
   output logic [NREQ-1:0]             grant,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [WIDTH-1:0]            res_data,
   output logic [id_width(NREQ)-1:0]   res_id,
   output logic                        res_valid,
   input  logic                        res_ready
);

   localparam int IDW = id_width(NREQ);

   state_t           state;
   state_t           state_nxt;
   logic [NREQ-1:0]  arb_gnt;
   logic [IDW-1:0]   arb_idx;
   logic             arb_any;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   idx_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt;
   logic [WIDTH-1:0] acc;
   logic [LEN_W-1:0] win_len;
   logic             last_word;
   logic             handoff;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req     (req),
      .ptr     (ptr),
      .gnt     (arb_gnt),
      .idx     (arb_idx),
      .req_any (arb_any)
   );

   assign win_len   = req_len[int'(arb_idx)*LEN_W +: LEN_W];
   assign last_word = in_valid && ((cnt + LEN_W'(1)) == len_q);
   assign handoff   = (state == DONE) && res_ready;

`ifdef XOR_SCHED_RR_EN
   // Pointer moves one past the winner when its result is taken.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         ptr <= '0;
      else if (handoff)
         ptr <= (idx_q == IDW'(NREQ-1)) ? '0 : idx_q + IDW'(1);
   end
`else
   assign ptr = '0;
`endif

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode; a zero-length burst skips ACCUM entirely.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (arb_any) state_nxt = (win_len == '0) ? DONE : ACCUM;
         ACCUM:   if (last_word) state_nxt = DONE;
         DONE:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant, latched winner, counter and accumulator.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant     <= '0;
         idx_q     <= '0;
         len_q     <= '0;
         cnt       <= '0;
         acc       <= '0;
         res_valid <= 1'b0;
      end else begin
         res_valid <= (state_nxt == DONE);
         unique case (state)
            IDLE: begin
               if (arb_any) begin
                  grant <= arb_gnt;
                  idx_q <= arb_idx;
                  len_q <= win_len;
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc <= acc ^ in_data;
                  cnt <= cnt + LEN_W'(1);
               end
            end
            DONE: begin
               if (res_ready) grant <= '0;
            end
            default: grant <= '0;
         endcase
      end
   end

   assign in_ready = (state == ACCUM);
   assign res_data = acc;
   assign res_id   = idx_q;

endmodule

// File: tb/tb_xor_reduce_sched.sv
// Directed bench for xor_reduce_sched (NREQ=4, WIDTH=32, LEN_W=8).
module tb_xor_reduce_sched;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_len = '0;
   logic [3:0]  grant;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] res_data;
   logic [1:0]  res_id;
   logic        res_valid;
   logic        res_ready = 1'b0;

   int errors = 0;
   int checks = 0;

   xor_reduce_sched #(.WIDTH(32), .NREQ(4), .LEN_W(8)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .req_len   (req_len),
      .grant     (grant),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_grant(input string tag);
      int n;
      n = 0;
      while (grant == '0 && n < 8) begin
         step();
         n++;
      end
      chk({tag, " grant seen"}, 32'(grant != '0), 32'd1);
   endtask

   task automatic handshake(input string tag);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk({tag, " grant dropped"}, 32'(grant), 32'd0);
      chk({tag, " res_valid dropped"}, 32'(res_valid), 32'd0);
   endtask

   logic [3:0] exp_g;
   logic [31:0] w3 [3];

   initial begin
      // Reset values
      #12;
      chk("rst grant", 32'(grant), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd0);
      chk("rst res_valid", 32'(res_valid), 32'd0);
      chk("rst res_data", res_data, 32'd0);
      chk("rst res_id", 32'(res_id), 32'd0);
      @(negedge clock) reset_n = 1'b1;
      step();

      // Single burst on requester 2
      w3[0] = 32'h0000_00FF; w3[1] = 32'h0000_0F0F; w3[2] = 32'h1234_0000;
      req = 4'b0100;
      req_len[16 +: 8] = 8'd3;
      step();
      chk("single grant", 32'(grant), 32'h4);
      chk("single in_ready", 32'(in_ready), 32'd1);
      req = '0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data = w3[i];
         step();
         if (i == 1) chk("single early res_valid", 32'(res_valid), 32'd0);
      end
      in_valid = 1'b0;
      chk("single res_valid", 32'(res_valid), 32'd1);
      chk("single res_data", res_data, 32'h1234_0FF0);
      chk("single res_id", 32'(res_id), 32'd2);
      chk("single in_ready done", 32'(in_ready), 32'd0);
      handshake("single");

      // Zero-length burst on requester 0
      req = 4'b0001;
      req_len[0 +: 8] = 8'd0;
      step();
      req = '0;
      chk("zero res_valid", 32'(res_valid), 32'd1);
      chk("zero in_ready", 32'(in_ready), 32'd0);
      chk("zero grant", 32'(grant), 32'h1);
      chk("zero res_data", res_data, 32'd0);
      chk("zero res_id", 32'(res_id), 32'd0);
      handshake("zero");

      // Fairness from a fresh reset: all four requesting, length 1
      #2 reset_n = 1'b0;
      @(negedge clock) reset_n = 1'b1;
      step();
      req = 4'b1111;
      req_len = {8'd1, 8'd1, 8'd1, 8'd1};
      for (int k = 0; k < 5; k++) begin
         wait_grant("fair");
`ifdef XOR_SCHED_RR_EN
         exp_g = 4'b0001 << (k % 4);
`else
         exp_g = 4'b0001;
`endif
         chk("fair grant order", 32'(grant), 32'(exp_g));
         in_valid = 1'b1;
         in_data = 32'hA0 + 32'(k);
         step();
         in_valid = 1'b0;
         chk("fair res_valid", 32'(res_valid), 32'd1);
         chk("fair res_data", res_data, 32'hA0 + 32'(k));
         handshake("fair");
      end
      req = '0;
      step();

      // Stalls and backpressure on requester 1
      req = 4'b0010;
      req_len[8 +: 8] = 8'd2;
      step();
      chk("stall grant", 32'(grant), 32'h2);
      req = '0;
      in_valid = 1'b1; in_data = 32'hDEAD_0000; step();
      in_valid = 1'b0; in_data = 32'hFFFF_FFFF; step();
      step();
      chk("stall in_ready", 32'(in_ready), 32'd1);
      chk("stall no res_valid", 32'(res_valid), 32'd0);
      in_valid = 1'b1; in_data = 32'h0000_BEEF; step();
      in_valid = 1'b0;
      req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         chk("bp res_valid", 32'(res_valid), 32'd1);
         chk("bp res_data", res_data, 32'hDEAD_BEEF);
         chk("bp res_id", 32'(res_id), 32'd1);
         chk("bp grant", 32'(grant), 32'h2);
         step();
      end
      req = '0;
      handshake("bp");

      // Reset in the middle of a burst on requester 3
      req = 4'b1000;
      req_len[24 +: 8] = 8'd5;
      step();
      chk("mid grant", 32'(grant), 32'h8);
      req = '0;
      in_valid = 1'b1; in_data = 32'h1111_1111; step();
      in_data = 32'h2222_2222; step();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("mid rst grant", 32'(grant), 32'd0);
      chk("mid rst in_ready", 32'(in_ready), 32'd0);
      chk("mid rst res_valid", 32'(res_valid), 32'd0);
      chk("mid rst res_data", res_data, 32'd0);
      chk("mid rst res_id", 32'(res_id), 32'd0);
      @(negedge clock) reset_n = 1'b1;
      step();
      req = 4'b1000;
      step();
      chk("mid regrant", 32'(grant), 32'h8);
      req = '0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = 32'd1 << i;
         step();
      end
      in_valid = 1'b0;
      chk("mid res_valid", 32'(res_valid), 32'd1);
      chk("mid res_data", res_data, 32'h0000_001F);
      chk("mid res_id", 32'(res_id), 32'd3);
      handshake("mid");

      // Maximum length burst, data = word index 1..255
      req = 4'b0001;
      req_len[0 +: 8] = 8'd255;
      step();
      chk("max grant", 32'(grant), 32'h1);
      req = '0;
      for (int i = 1; i <= 255; i++) begin
         in_valid = 1'b1;
         in_data = 32'(i);
         step();
         if (i == 254) begin
            chk("max early res_valid", 32'(res_valid), 32'd0);
            chk("max in_ready", 32'(in_ready), 32'd1);
         end
      end
      in_valid = 1'b0;
      chk("max res_valid", 32'(res_valid), 32'd1);
      chk("max res_data", res_data, 32'd0);
      chk("max res_id", 32'(res_id), 32'd0);
      chk("max in_ready done", 32'(in_ready), 32'd0);
      handshake("max");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/xor_reduce_sched.md
# xor_reduce_sched

Round-robin scheduler that shares one WIDTH-bit XOR accumulator between NREQ requesters. Each requester asks for a reduction of a burst of words. The scheduler grants one requester at a time, then streams its words through the accumulator. It returns the XOR of the whole burst, tagged with the requester index. It sits between the GPU-side parity/checksum clients and the shared XOR datapath, so the datapath needs only one instance.

## Interface
- WIDTH, 32, data and result width in bits
- NREQ, 4, number of requesters (2..16)
- LEN_W, 8, width of the burst-length field; max burst 2^LEN_W-1 words
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  NREQ  request bit per requester; held high until granted
- req_len  in  NREQ*LEN_W  burst length per requester, packed, requester i at bits [i*LEN_W +: LEN_W]
- grant  out  NREQ  one-hot grant, held for the whole burst
- in_data  in  WIDTH  data word from the granted requester (muxed externally)
- in_valid  in  1  in_data valid
- in_ready  out  1  scheduler accepts in_data this cycle
- res_data  out  WIDTH  XOR of all burst words
- res_id  out  $clog2(NREQ)  index of the requester the result belongs to
- res_valid  out  1  result valid
- res_ready  in  1  consumer takes the result

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - If any req bit is high, pick the winner by priority (see Configuration).
  - Latch the winner's index and req_len.
  - Clear the accumulator and count.
  - Assert grant next cycle.
  - Go to ACCUM, or straight to DONE if the latched length is 0.
- ACCUM:
  - in_ready=1.
  - On in_valid: acc <= acc ^ in_data and count <= count+1.
  - When the accepted word is word number len, go to DONE.
  - in_valid low stalls the burst indefinitely; there is no timeout.
- DONE:
  - res_valid=1, res_data=acc, res_id=latched index.
  - grant stays asserted.
  - On res_ready: drop grant, update the round-robin pointer to winner+1 mod NREQ, return to IDLE.
- Length 0: result is 0, presented in DONE; no words are consumed.
- Requests that drop before being granted are simply not considered. Requests that change while another requester is granted are ignored until the next IDLE. req_len is sampled only at grant.
- Arithmetic: count is LEN_W bits and never wraps, because the burst terminates at len ≤ 2^LEN_W-1. acc is WIDTH bits, pure bitwise XOR, with no carries.

## Timing
- Reset values: grant=0, in_ready=0, res_valid=0, res_data=0, res_id=0, round-robin pointer=0, state=IDLE.
- Arbitration latency: req high in cycle t (in IDLE) gives grant high and in_ready high from cycle t+1.
- Throughput: one word per cycle in ACCUM.
- The final word, accepted in cycle u, gives res_valid high in u+1, with res_data already including that word.
- A res_ready/res_valid handshake in cycle v gives grant low and state IDLE in v+1. The earliest next grant is v+2, so there is one IDLE bubble between bursts.
- The result is held stable while res_valid=1 and res_ready=0.
- Reset asserted mid-burst: all outputs clear asynchronously and the partial accumulation is discarded. The requester must re-request.
- All outputs are registered except in_ready, which is decoded from state registers only and never from inputs.

## Configuration
- XOR_SCHED_RR_EN defined:
  - Round-robin arbitration.
  - Search starts at the pointer index and wraps.
  - The pointer advances past each winner when its result is handed off.
- Not defined:
  - Fixed priority: lowest set req index wins.
  - The pointer register is removed.
- All other behaviour is identical in both builds.

## Structure
- Shared package xor_sched_pkg: state enum (IDLE, ACCUM, DONE), the ID-width function and the max-length constant.
- One natural sub-module, rr_arbiter: combinational NREQ-way one-hot picker with a pointer input. It is also used in the fixed-priority build with the pointer tied to 0.
- Datapath accumulator and FSM are in the top module.

## Test plan
- Single burst, RR build:
  - Stimulus: req[2]=1, len=3, words 0x0000_00FF, 0x0000_0F0F, 0x1234_0000.
  - Response: grant=4'b0100 one cycle later; res_data=0x1234_0FF0, res_id=2.
  - Timing: res_valid is high one cycle after the third word.
- Zero length:
  - Stimulus: req[0], len=0.
  - Response: DONE reached without in_ready ever high; res_data=0, res_id=0.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held continuously, each len=1.
  - Response: grant order 0,1,2,3,0. Fixed-priority build: grant order 0,0,0.
- Stalls and backpressure:
  - Stimulus: in_valid toggling 1-0-0-1 over a len=2 burst, then res_ready low for 5 cycles.
  - Response: correct XOR; res_data and res_id stable throughout; grant held until the handshake.
- Reset mid-burst:
  - Stimulus: assert reset_n low after 2 of 5 words; release; re-request with 5 words.
  - Response: outputs clear immediately; the second result covers only the new 5 words.
- Maximum length:
  - Stimulus: len=255 with data = the word index.
  - Response: res_data = XOR of 1..255, which is 0x0000_0000.
  - Check: count does not wrap.
